// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint controller: turns a run switch, a bouncing step
// button and a PC breakpoint into a single-cycle CPU clock-enable pulse.
//
// Interface semantics: there is no valid/ready handshake here. cpu_tick is
// a one-cycle enable qualifier on clk; the CPU advances exactly once per
// cycle in which cpu_tick is high, and pc is expected to stay stable
// between ticks. state is the live FSM encoding, exported for observation.
module cpu_run_ctrl #(
  parameter int DIV_MAX   = 99999,
  parameter int DB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  output logic        cpu_tick,
  output logic [1:0]  state,
  output logic        halted,
  output logic [31:0] tick_count
);

  localparam int DIV_W = (DIV_MAX < 1) ? 1 : $clog2(DIV_MAX + 1);
  localparam int DB_W  = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_BRK  = 2'b11
  } state_t;

  // Button path registers
  logic            sync1_q, sync2_q;
  logic            db_level_q, db_level_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            step_pulse_q, step_pulse_d;

  // Control registers
  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic [31:0]      count_q, count_d;

  logic sample_diff;
  logic db_hit;
  logic bp_hit;

  // Debounce next-state: any sample equal to the accepted level restarts
  // the count; DB_CYCLES consecutive differing samples accept the new level.
  // Only a newly accepted high level produces a step pulse.
  always_comb begin
    sample_diff  = (sync2_q != db_level_q);
    db_hit       = sample_diff && (db_cnt_q == DB_LAST);
    db_cnt_d     = '0;
    db_level_d   = db_level_q;
    step_pulse_d = 1'b0;
    if (db_hit) begin
      db_level_d   = sync2_q;
      step_pulse_d = sync2_q;
    end else if (sample_diff) begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Synchroniser and debounce registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      db_cnt_q     <= '0;
      db_level_q   <= 1'b0;
      step_pulse_q <= 1'b0;
    end else begin
      sync1_q      <= step_btn;
      sync2_q      <= sync1_q;
      db_cnt_q     <= db_cnt_d;
      db_level_q   <= db_level_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign bp_hit = bp_en && (pc == bp_addr);

  // Control next-state: the divider only runs in RUN and is zero elsewhere,
  // so every RUN entry waits a full DIV_MAX+1 cycles before its first tick.
  // A tick is raised on the same edge that moves into STEP or that ends a
  // RUN period, and the tick counter advances on that same edge.
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    tick_d  = 1'b0;
    case (state_q)
      ST_HALT: begin
        if (run_sw) begin
          state_d = ST_RUN;
        end else if (step_pulse_q) begin
          state_d = ST_STEP;
          tick_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (!run_sw) begin
          state_d = ST_HALT;
        end else if (div_q == DIV_LAST) begin
          if (bp_hit) begin
            state_d = ST_BRK;
          end else begin
            tick_d = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_STEP: begin
        // Breakpoint deliberately not consulted: this is how the CPU
        // steps off the instruction it froze on.
        state_d = ST_HALT;
      end
      ST_BRK: begin
        if (step_pulse_q) begin
          state_d = ST_STEP;
          tick_d  = 1'b1;
        end else if (!run_sw) begin
          state_d = ST_HALT;
        end
      end
      default: state_d = ST_HALT;
    endcase
    count_d = tick_d ? (count_q + 32'd1) : count_q;
  end

  // Control FSM, divider, tick and tick counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_HALT;
      div_q   <= '0;
      tick_q  <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      count_q <= count_d;
    end
  end

  assign cpu_tick   = tick_q;
  assign state      = state_q;
  assign halted     = (state_q == ST_HALT) || (state_q == ST_BRK);
  assign tick_count = count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with DIV_MAX=3, DB_CYCLES=4 and a PC
// model that advances by 4 on every CPU tick.
module tb_cpu_run_ctrl;

  localparam logic [1:0] S_HALT = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STEP = 2'b10;
  localparam logic [1:0] S_BRK  = 2'b11;

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run_sw = 1'b0;
  logic        step_btn = 1'b0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'd0;
  logic [31:0] pc;
  logic        cpu_tick;
  logic [1:0]  state;
  logic        halted;
  logic [31:0] tick_count;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.DIV_MAX(3), .DB_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .run_sw     (run_sw),
    .step_btn   (step_btn),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .cpu_tick   (cpu_tick),
    .state      (state),
    .halted     (halted),
    .tick_count (tick_count)
  );

  // CPU model: executes one instruction per enabled edge
  always @(posedge clk or negedge rst) begin
    if (!rst) pc <= 32'd0;
    else if (cpu_tick) pc <= pc + 32'd4;
  end

  // Scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  int tick_seen = 0;
  int step_seen = 0;
  int rule_viol = 0;
  logic prev_tick = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: samples pre-edge values; checks the PC each tick executes and
  // the tick rules (no back-to-back ticks, none while halted)
  always @(posedge clk) begin
    if (rst) begin
      if (cpu_tick) begin
        tick_seen++;
        if (prev_tick) rule_viol++;
        if (state == S_HALT || state == S_BRK) rule_viol++;
        if (exp_q.size() > 0) check_eq("tick_pc", pc, exp_q.pop_front());
      end
      if (state == S_STEP) step_seen++;
      prev_tick = cpu_tick;
    end else begin
      prev_tick = 1'b0;
    end
  end

  // Driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    run_sw   = 1'b0;
    step_btn = 1'b0;
    cyc(2);
    rst = 1'b1;
  endtask

  int base;

  initial begin
    do_reset();
    check_eq("rst_state", {30'd0, state}, {30'd0, S_HALT});
    check_eq("rst_tick", {31'd0, cpu_tick}, 32'd0);
    check_eq("rst_halted", {31'd0, halted}, 32'd1);
    check_eq("rst_count", tick_count, 32'd0);

    // 1: free run, first tick 4 cycles after entry, then every 4
    bp_en = 1'b0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd4); exp_q.push_back(32'd8);
    exp_q.push_back(32'd12); exp_q.push_back(32'd16);
    run_sw = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      cyc(1);
      check_eq("t1_tick", {31'd0, cpu_tick}, {31'd0, (k >= 5 && ((k - 5) % 4) == 0)});
    end
    check_eq("t1_count", tick_count, 32'd5);
    check_eq("t1_state", {30'd0, state}, {30'd0, S_RUN});
    check_eq("t1_halted", {31'd0, halted}, 32'd0);
    // drop run_sw on the terminal-count cycle
    run_sw = 1'b0;
    cyc(1);
    check_eq("t5a_state", {30'd0, state}, {30'd0, S_HALT});
    check_eq("t5a_tick", {31'd0, cpu_tick}, 32'd0);
    check_eq("t5a_count", tick_count, 32'd5);
    check_eq("t1_expq", exp_q.size(), 32'd0);

    // 2: bouncy step press, then release
    do_reset();
    base = step_seen;
    for (int i = 0; i < 20; i++) begin
      step_btn = ((i / 2) % 2) == 0;
      cyc(1);
    end
    step_btn = 1'b1;
    cyc(10);
    check_eq("t2_ticks", tick_seen - (tick_seen - tick_count), tick_count);
    check_eq("t2_count", tick_count, 32'd1);
    check_eq("t2_steps", step_seen - base, 32'd1);
    check_eq("t2_state", {30'd0, state}, {30'd0, S_HALT});
    check_eq("t2_pc", pc, 32'd4);
    base = tick_seen;
    step_btn = 1'b0;
    cyc(10);
    check_eq("t2_release", tick_seen - base, 32'd0);
    check_eq("t2_rel_count", tick_count, 32'd1);

    // 3: breakpoint at 0xC
    do_reset();
    base = tick_seen;
    bp_en   = 1'b1;
    bp_addr = 32'h0000_000C;
    exp_q.push_back(32'd0); exp_q.push_back(32'd4); exp_q.push_back(32'd8);
    run_sw = 1'b1;
    cyc(17);
    check_eq("t3_state", {30'd0, state}, {30'd0, S_BRK});
    check_eq("t3_halted", {31'd0, halted}, 32'd1);
    check_eq("t3_count", tick_count, 32'd3);
    check_eq("t3_tick", {31'd0, cpu_tick}, 32'd0);
    cyc(40);
    check_eq("t3_hold_ticks", tick_seen - base, 32'd3);
    check_eq("t3_hold_state", {30'd0, state}, {30'd0, S_BRK});
    check_eq("t3_pc", pc, 32'h0000_000C);
    check_eq("t3_expq", exp_q.size(), 32'd0);

    // 4: step off the breakpoint with run_sw still high, then RUN resumes
    exp_q.push_back(32'h0000_000C); exp_q.push_back(32'h0000_0010);
    step_btn = 1'b1;
    cyc(7);
    check_eq("t4_step_tick", {31'd0, cpu_tick}, 32'd1);
    check_eq("t4_step_state", {30'd0, state}, {30'd0, S_STEP});
    check_eq("t4_step_count", tick_count, 32'd4);
    cyc(1);
    check_eq("t4_halt_state", {30'd0, state}, {30'd0, S_HALT});
    check_eq("t4_pc", pc, 32'h0000_0010);
    cyc(1);
    check_eq("t4_run_state", {30'd0, state}, {30'd0, S_RUN});
    cyc(3);
    check_eq("t4_no_tick", {31'd0, cpu_tick}, 32'd0);
    cyc(1);
    check_eq("t4_run_tick", {31'd0, cpu_tick}, 32'd1);
    check_eq("t4_run_count", tick_count, 32'd5);
    step_btn = 1'b0;

    // 5a: run_sw dropped on the terminal-count cycle (divider at 3)
    cyc(3);
    run_sw = 1'b0;
    cyc(1);
    check_eq("t5a2_state", {30'd0, state}, {30'd0, S_HALT});
    check_eq("t5a2_tick", {31'd0, cpu_tick}, 32'd0);
    check_eq("t5a2_count", tick_count, 32'd5);
    check_eq("t4_expq", exp_q.size(), 32'd0);

    // 5b: run_sw rises in the cycle the step pulse is present
    cyc(10);
    base = step_seen;
    step_btn = 1'b1;
    cyc(6);
    run_sw = 1'b1;
    cyc(1);
    check_eq("t5b_state", {30'd0, state}, {30'd0, S_RUN});
    check_eq("t5b_tick", {31'd0, cpu_tick}, 32'd0);
    check_eq("t5b_count", tick_count, 32'd5);
    cyc(3);
    check_eq("t5b_no_tick", {31'd0, cpu_tick}, 32'd0);
    cyc(1);
    check_eq("t5b_run_tick", {31'd0, cpu_tick}, 32'd1);
    check_eq("t5b_run_count", tick_count, 32'd6);
    check_eq("t5b_no_step", step_seen - base, 32'd0);

    // 6: asynchronous reset while cpu_tick is high
    #2;
    rst = 1'b0;
    #1;
    check_eq("t6_tick", {31'd0, cpu_tick}, 32'd0);
    check_eq("t6_state", {30'd0, state}, {30'd0, S_HALT});
    check_eq("t6_halted", {31'd0, halted}, 32'd1);
    check_eq("t6_count", tick_count, 32'd0);
    run_sw   = 1'b0;
    step_btn = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cyc(3);
    check_eq("t6_post_state", {30'd0, state}, {30'd0, S_HALT});
    check_eq("t6_post_count", tick_count, 32'd0);

    check_eq("tick_rules", rule_viol, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
